// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared widths, source encoding and defaults for the writeback arbiter
package rf_wb_arbiter_pkg;

  localparam int REG_ADDR_W       = 5;
  localparam int XLEN             = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  function automatic logic is_real_reg(input logic [REG_ADDR_W-1:0] idx);
    return idx != '0;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-destination scoreboard with set-over-clear priority and hazard lookup
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_idx_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_idx_i,
  input  logic [REG_ADDR_W-1:0] rs_idx_i,
  input  logic [REG_ADDR_W-1:0] rt_idx_i,
  output logic [31:0]           pending_o,
  output logic                  hazard_rs_o,
  output logic                  hazard_rt_o
);

  logic [31:0] pending_q;
  logic [31:0] pending_d;

  // Clear is applied first so a same-edge issue to the same register keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) pending_d[clr_idx_i] = 1'b0;
    if (set_en_i && is_real_reg(set_idx_i)) pending_d[set_idx_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign pending_o   = pending_q;
  assign hazard_rs_o = pending_q[rs_idx_i];
  assign hazard_rt_o = pending_q[rt_idx_i];

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-requester arbiter for the regfile write port with starvation guard
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_we,
  input  logic [REG_ADDR_W-1:0] a_rdc,
  input  logic [XLEN-1:0]       a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_rdc,
  input  logic [XLEN-1:0]       b_data,
  output logic                  b_ready,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rdc,
  input  logic [REG_ADDR_W-1:0] rsc,
  input  logic [REG_ADDR_W-1:0] rtc,
  output logic                  hazard_rs,
  output logic                  hazard_rt,
  output logic                  RF_W,
  output logic [REG_ADDR_W-1:0] rdc,
  output logic [XLEN-1:0]       rd,
  output logic                  waw_err
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic                  a_req, b_req, grant_a, grant_b;
  logic [CNT_W-1:0]      starve_q, starve_d;
  logic                  rf_w_q, rf_w_d;
  logic [REG_ADDR_W-1:0] rdc_q, rdc_d;
  logic [XLEN-1:0]       rd_q, rd_d;
  src_e                  out_src_q, out_src_d;
  logic                  waw_q, waw_d;
  logic [31:0]           pending;

  // Writes to r0 never compete for the port; they are simply acknowledged.
  assign a_req   = a_we & is_real_reg(a_rdc);
  assign b_req   = b_valid & is_real_reg(b_rdc);
  assign grant_b = b_req & (~a_req | (starve_q == LIMIT));
  assign grant_a = a_req & ~grant_b;

  assign a_ready = (a_we & grant_a) | (a_we & ~is_real_reg(a_rdc));
  assign b_ready = (b_valid & grant_b) | (b_valid & ~is_real_reg(b_rdc));

  always_comb begin
    starve_d  = starve_q;
    rf_w_d    = grant_a | grant_b;
    rdc_d     = rdc_q;
    rd_d      = rd_q;
    out_src_d = out_src_q;
    waw_d     = waw_q | (grant_a & pending[a_rdc]);

    if (!b_valid || grant_b)                starve_d = '0;
    else if (b_req && (starve_q < LIMIT))   starve_d = starve_q + 1'b1;

    if (grant_b) begin
      rdc_d     = b_rdc;
      rd_d      = b_data;
      out_src_d = SRC_B;
    end else if (grant_a) begin
      rdc_d     = a_rdc;
      rd_d      = a_data;
      out_src_d = SRC_A;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      rf_w_q    <= 1'b0;
      rdc_q     <= '0;
      rd_q      <= '0;
      out_src_q <= SRC_A;
      waw_q     <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      rf_w_q    <= rf_w_d;
      rdc_q     <= rdc_d;
      rd_q      <= rd_d;
      out_src_q <= out_src_d;
      waw_q     <= waw_d;
    end
  end

  // Pending clears on the same edge the regfile captures the B result.
  rf_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en_i    (iss_valid),
    .set_idx_i   (iss_rdc),
    .clr_en_i    (rf_w_q && (out_src_q == SRC_B)),
    .clr_idx_i   (rdc_q),
    .rs_idx_i    (rsc),
    .rt_idx_i    (rtc),
    .pending_o   (pending),
    .hazard_rs_o (hazard_rs),
    .hazard_rt_o (hazard_rt)
  );

  assign RF_W    = rf_w_q;
  assign rdc     = rdc_q;
  assign rd      = rd_q;
  assign waw_err = waw_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_we, b_valid, iss_valid;
  logic [4:0]  a_rdc, b_rdc, iss_rdc, rsc, rtc;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, hazard_rs, hazard_rt, RF_W, waw_err;
  logic [4:0]  rdc;
  logic [31:0] rd;

  int checks   = 0;
  int failures = 0;

  rf_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .a_we(a_we), .a_rdc(a_rdc), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rdc(b_rdc), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_rdc(iss_rdc),
    .rsc(rsc), .rtc(rtc), .hazard_rs(hazard_rs), .hazard_rt(hazard_rt),
    .RF_W(RF_W), .rdc(rdc), .rd(rd), .waw_err(waw_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; a_we = 0; b_valid = 0; iss_valid = 0;
    a_rdc = 0; b_rdc = 0; iss_rdc = 0; rsc = 0; rtc = 0; a_data = 0; b_data = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_rf_w", RF_W, 0);
    check("rst_rdc", rdc, 0);
    check("rst_rd", rd, 0);
    check("rst_hz_rs", hazard_rs, 0);
    check("rst_hz_rt", hazard_rt, 0);
    check("rst_waw", waw_err, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);

    // A-only write
    a_we = 1; a_rdc = 5; a_data = 32'h1234;
    #1;
    check("a_only_ready", a_ready, 1);
    check("a_only_b_ready", b_ready, 0);
    tick();
    a_we = 0;
    check("a_only_rf_w", RF_W, 1);
    check("a_only_rdc", rdc, 5);
    check("a_only_rd", rd, 32'h1234);
    tick();
    check("a_only_rf_w_off", RF_W, 0);
    check("a_only_rdc_hold", rdc, 5);

    // Scoreboard lifecycle
    iss_valid = 1; iss_rdc = 8;
    tick();
    iss_valid = 0; rsc = 8; rtc = 5;
    #1;
    check("sb_hz_rs_set", hazard_rs, 1);
    check("sb_hz_rt_clear", hazard_rt, 0);
    b_valid = 1; b_rdc = 8; b_data = 32'hDEADBEEF;
    #1;
    check("sb_b_ready", b_ready, 1);
    tick();
    b_valid = 0;
    #1;
    check("sb_rf_w", RF_W, 1);
    check("sb_rdc", rdc, 8);
    check("sb_rd", rd, 32'hDEADBEEF);
    check("sb_hz_held", hazard_rs, 1);
    tick();
    check("sb_hz_drop", hazard_rs, 0);
    check("sb_rf_w_off", RF_W, 0);

    // Starvation: B refused for 4 cycles, granted on the 5th
    a_we = 1; a_rdc = 10; a_data = 32'hAAAA;
    b_valid = 1; b_rdc = 3; b_data = 32'h33;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("starve_b_wait%0d", i), b_ready, 0);
      check($sformatf("starve_a_go%0d", i), a_ready, 1);
      tick();
      check($sformatf("starve_out_a%0d", i), rdc, 10);
    end
    #1;
    check("starve_b_forced", b_ready, 1);
    check("starve_a_held", a_ready, 0);
    tick();
    b_valid = 0;
    check("starve_out_b_rdc", rdc, 3);
    check("starve_out_b_rd", rd, 32'h33);
    check("starve_out_b_we", RF_W, 1);
    #1;
    check("starve_a_resume", a_ready, 1);
    tick();
    a_we = 0;
    check("starve_out_a_again", rdc, 10);
    tick();

    // r0 request beside a real write
    a_we = 1; a_rdc = 7; a_data = 32'h77;
    b_valid = 1; b_rdc = 0; b_data = 32'hBAD;
    #1;
    check("zero_a_ready", a_ready, 1);
    check("zero_b_ready", b_ready, 1);
    tick();
    a_we = 0; b_valid = 0;
    check("zero_rf_w", RF_W, 1);
    check("zero_rdc", rdc, 7);
    check("zero_rd", rd, 32'h77);
    tick();
    check("zero_rf_w_off", RF_W, 0);

    // Issue and clear of the same register on one edge
    iss_valid = 1; iss_rdc = 9;
    tick();
    iss_valid = 0;
    b_valid = 1; b_rdc = 9; b_data = 32'h99;
    rsc = 9;
    #1;
    check("coll_b_ready", b_ready, 1);
    tick();
    b_valid = 0;
    iss_valid = 1; iss_rdc = 9;
    #1;
    check("coll_hz_pre", hazard_rs, 1);
    tick();
    iss_valid = 0;
    check("coll_set_wins", hazard_rs, 1);
    b_valid = 1; b_rdc = 9;
    tick();
    b_valid = 0;
    tick();
    check("coll_later_clear", hazard_rs, 0);

    // WAW detection
    iss_valid = 1; iss_rdc = 4;
    tick();
    iss_valid = 0; rtc = 4;
    #1;
    check("waw_pre", waw_err, 0);
    check("waw_hz_rt", hazard_rt, 1);
    a_we = 1; a_rdc = 4; a_data = 32'h44;
    #1;
    check("waw_a_ready", a_ready, 1);
    tick();
    a_we = 0;
    check("waw_write", RF_W, 1);
    check("waw_rdc", rdc, 4);
    check("waw_set", waw_err, 1);
    tick(); tick();
    check("waw_sticky", waw_err, 1);

    // Reset while B waits with two refusals accumulated
    a_we = 1; a_rdc = 10; a_data = 32'h5A5A;
    b_valid = 1; b_rdc = 3; b_data = 32'h3C;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0; a_we = 0; b_valid = 0; rsc = 4; rtc = 4;
    #1;
    check("mid_rst_rf_w", RF_W, 0);
    check("mid_rst_rdc", rdc, 0);
    check("mid_rst_rd", rd, 0);
    check("mid_rst_waw", waw_err, 0);
    check("mid_rst_hz_rs", hazard_rs, 0);
    check("mid_rst_hz_rt", hazard_rt, 0);
    a_we = 1; b_valid = 1;
    tick(); tick(); tick();
    check("mid_rst_cnt_b_wait", b_ready, 0);
    tick();
    check("mid_rst_cnt_b_go", b_ready, 1);
    a_we = 0; b_valid = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
